// File: rtl/npc_seq_pkg.sv
// Shared types and encodings for the NPC multi-cycle execution sequencer.
package npc_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_MEM_REQ    = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_HALT       = 3'd7
    } seq_state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] PC_SEL_JAL  = 2'd1;
    localparam logic [1:0] PC_SEL_JALR = 2'd2;

    localparam logic [1:0] HALT_EBREAK  = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL = 2'd1;
    localparam logic [1:0] HALT_TIMEOUT = 2'd2;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Decoder branch code to PC mux select; reserved codes fall back to pc+4.
    function automatic logic [1:0] pc_sel_of(input logic [2:0] br);
        logic [1:0] sel;
        case (br)
            3'd1:    sel = PC_SEL_JAL;
            3'd2:    sel = PC_SEL_JALR;
            default: sel = PC_SEL_SEQ;
        endcase
        return sel;
    endfunction

    // States that wait on an external handshake.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
               (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
    endfunction

endpackage

// File: rtl/exec_sequencer_watchdog.sv
// Wait-state watchdog: down-counter reloaded on every state change, flags
// expiry once the current wait state has lasted LIMIT cycles.
module seq_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    // Reload outside wait states or on a transition, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (!active || clear) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = active && (cnt == '0);

endmodule

// File: rtl/exec_sequencer.sv
// NPC multi-cycle execution sequencer: fetch, decode, execute, memory and
// writeback, one instruction at a time.
// Optional build macro SEQ_TIMEOUT_EN adds a wait-state watchdog that halts
// with cause 2 after TIMEOUT_CYCLES cycles in one wait state.
//
// state        | meaning
// -------------+--------------------------------------------------
// FETCH_REQ    | imem request held until accepted
// FETCH_WAIT   | waiting for instruction, latched into ir
// DECODE       | decoder settles; illegal/ebreak halt here
// EXEC         | ALU settles; loads/stores branch to memory
// MEM_REQ      | dmem request held until accepted
// MEM_WAIT     | waiting for load data / store completion
// WB           | single-cycle retire: pc_we, rf_we, instret++
// HALT         | absorbing stop, only reset exits
module exec_sequencer
    import npc_seq_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     ir,
    input  logic            dec_reg_wr,
    input  logic [2:0]      dec_branch,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_is_ebreak,
    input  logic            dec_illegal,
    output logic            dmem_req_valid,
    output logic            dmem_req_we,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            halt,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] instret
);

    seq_state_t state, state_nx;
    logic       wd_expired;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (is_wait_state(state)),
        .clear   (state_nx != state),
        .expired (wd_expired)
    );
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH_REQ;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; watchdog expiry overrides any wait-state progress.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH_REQ:  if (imem_req_ready) state_nx = S_FETCH_WAIT;
            S_FETCH_WAIT: if (imem_rsp_valid) state_nx = S_DECODE;
            S_DECODE:     state_nx = (dec_illegal || dec_is_ebreak) ? S_HALT : S_EXEC;
            S_EXEC:       state_nx = (dec_is_load || dec_is_store) ? S_MEM_REQ : S_WB;
            S_MEM_REQ:    if (dmem_req_ready) state_nx = S_MEM_WAIT;
            S_MEM_WAIT:   if (dmem_rsp_valid) state_nx = S_WB;
            S_WB:         state_nx = S_FETCH_REQ;
            S_HALT:       state_nx = S_HALT;
            default:      state_nx = S_FETCH_REQ;
        endcase
        if (wd_expired && is_wait_state(state)) begin
            state_nx = S_HALT;
        end
    end

    // Moore strobes decoded from the current state only.
    always_comb begin
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_SEL_SEQ;
        rf_we          = 1'b0;
        wb_sel         = 1'b0;
        halt           = 1'b0;
        case (state)
            S_FETCH_REQ: imem_req_valid = 1'b1;
            S_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_req_we    = dec_is_store;
            end
            S_WB: begin
                rf_we  = dec_reg_wr & ~dec_is_store;
                wb_sel = dec_is_load;
                pc_we  = 1'b1;
                pc_sel = pc_sel_of(dec_branch);
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    // Instruction register: captured only on a response in FETCH_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= NOP_INSN;
        end else if (state == S_FETCH_WAIT && imem_rsp_valid) begin
            ir <= imem_rsp_data;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state == S_WB) begin
            instret <= instret + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    // Halt cause captured on entry to HALT; decode-time halts favour illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_cause <= HALT_EBREAK;
        end else if (state != S_HALT && state_nx == S_HALT) begin
            if (state == S_DECODE) begin
                halt_cause <= dec_illegal ? HALT_ILLEGAL : HALT_EBREAK;
            end else begin
                halt_cause <= HALT_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer with zero-wait memory models.
module tb_exec_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_rsp_data, ir;
    logic        dec_reg_wr, dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal;
    logic [2:0]  dec_branch;
    logic        dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid;
    logic        pc_we, rf_we, wb_sel, halt;
    logic [1:0]  pc_sel, halt_cause;
    logic [63:0] instret;

    exec_sequencer #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .ir(ir),
        .dec_reg_wr(dec_reg_wr), .dec_branch(dec_branch), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
        .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .halt(halt), .halt_cause(halt_cause), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic        reg_wr;
        logic [2:0]  br;
        logic        ld;
        logic        st;
        int          lat;
        logic        rf;
        logic [1:0]  sel;
        logic        wbs;
        logic        mem;
        logic        dwe;
    } vec_t;

    vec_t vecs[6];

    int          n_cmp = 0;
    int          n_fail = 0;
    logic        ipend = 1'b0, dpend = 1'b0;
    logic        irdy_cfg = 1'b1, drdy_cfg = 1'b1;
    logic [31:0] cur_insn = NOP;
    logic [63:0] exp_instret = 64'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge from the memory models, sample 1ns later.
    task automatic tick(input logic stale);
        @(negedge clk);
        imem_req_ready = irdy_cfg;
        dmem_req_ready = drdy_cfg;
        imem_rsp_valid = ipend | stale;
        imem_rsp_data  = ipend ? cur_insn : 32'hbadc_0de5;
        dmem_rsp_valid = dpend;
        #1;
        ipend = imem_req_valid && imem_req_ready;
        dpend = dmem_req_valid && dmem_req_ready;
    endtask

    task automatic set_dec(input logic rw, input logic [2:0] br, input logic ld,
                           input logic st, input logic eb, input logic il);
        dec_reg_wr = rw; dec_branch = br; dec_is_load = ld;
        dec_is_store = st; dec_is_ebreak = eb; dec_illegal = il;
    endtask

    // Assert reset at a negedge, check reset outputs, release just after a posedge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        ipend = 1'b0; dpend = 1'b0;
        imem_rsp_valid = 1'b0; dmem_rsp_valid = 1'b0;
        #1;
        chk({tag, "/imem_req_valid"}, 64'(imem_req_valid), 64'd1);
        chk({tag, "/strobes"}, 64'({dmem_req_valid, dmem_req_we, pc_we, rf_we}), 64'd0);
        chk({tag, "/sel"}, 64'({pc_sel, wb_sel}), 64'd0);
        chk({tag, "/halt"}, 64'({halt, halt_cause}), 64'd0);
        chk({tag, "/ir"}, 64'(ir), 64'(NOP));
        chk({tag, "/instret"}, instret, 64'd0);
        exp_instret = 64'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_insn(input vec_t v);
        int   cyc = 0, rfn = 0, pcn = 0, dreq = 0;
        logic [1:0] sel = 2'd0;
        logic wbs = 1'b0, dwe = 1'b0;
        bit   done = 1'b0;
        cur_insn = v.insn;
        set_dec(v.reg_wr, v.br, v.ld, v.st, 1'b0, 1'b0);
        while (!done && cyc < 40) begin
            tick(1'b0);
            cyc++;
            if (cyc == 1) chk({v.name, "/fetch_req"}, 64'(imem_req_valid), 64'd1);
            if (dmem_req_valid) begin dreq++; dwe = dmem_req_we; end
            if (rf_we) rfn++;
            if (pc_we) begin
                pcn++; sel = pc_sel; wbs = wb_sel; done = 1'b1;
                chk({v.name, "/ir"}, 64'(ir), 64'(v.insn));
            end
        end
        chk({v.name, "/latency"}, 64'(cyc), 64'(v.lat));
        chk({v.name, "/pc_we_count"}, 64'(pcn), 64'd1);
        chk({v.name, "/rf_we_count"}, 64'(rfn), 64'(v.rf));
        chk({v.name, "/pc_sel"}, 64'(sel), 64'(v.sel));
        chk({v.name, "/wb_sel"}, 64'(wbs), 64'(v.wbs));
        chk({v.name, "/dmem_req_cycles"}, 64'(dreq), v.mem ? 64'd1 : 64'd0);
        chk({v.name, "/dmem_req_we"}, 64'(dwe), 64'(v.dwe));
        exp_instret++;
        @(posedge clk);
        #1;
        chk({v.name, "/instret"}, instret, exp_instret);
    endtask

    task automatic run_halt(input string tag, input logic il, input logic eb, input logic [1:0] cause);
        int cyc = 0, strobes = 0, bad = 0;
        cur_insn = 32'h0010_0073;
        set_dec(1'b1, 3'd1, 1'b0, 1'b0, eb, il);
        while (!halt && cyc < 40) begin
            tick(1'b0);
            cyc++;
            if (pc_we || rf_we) strobes++;
        end
        chk({tag, "/cycles_to_halt"}, 64'(cyc), 64'd4);
        chk({tag, "/halt"}, 64'(halt), 64'd1);
        chk({tag, "/cause"}, 64'(halt_cause), 64'(cause));
        chk({tag, "/no_strobe"}, 64'(strobes), 64'd0);
        for (int i = 0; i < 100; i++) begin
            tick(1'b0);
            if (!halt || pc_we || rf_we || imem_req_valid || dmem_req_valid) bad++;
        end
        chk({tag, "/sticky_100"}, 64'(bad), 64'd0);
        chk({tag, "/cause_held"}, 64'(halt_cause), 64'(cause));
        chk({tag, "/instret_frozen"}, instret, exp_instret);
        do_reset({tag, "/reset_exit"});
    endtask

    // Abandon an outstanding fetch or load by resetting in the wait state.
    task automatic reset_mid(input string tag, input bit in_mem);
        int cyc = 0, strobes = 0;
        bit hit = 1'b0;
        cur_insn = 32'h0001_3083;
        set_dec(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        while (!hit && cyc < 20) begin
            tick(1'b0);
            cyc++;
            if (pc_we || rf_we) strobes++;
            hit = in_mem ? dpend : ipend;
        end
        chk({tag, "/reached_wait"}, 64'(hit), 64'd1);
        do_reset(tag);
        irdy_cfg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(i == 0);
            if (pc_we || rf_we || !imem_req_valid) strobes++;
        end
        irdy_cfg = 1'b1;
        chk({tag, "/no_strobe"}, 64'(strobes), 64'd0);
        chk({tag, "/stale_rsp_ignored"}, 64'(ir), 64'(NOP));
        chk({tag, "/instret"}, instret, 64'd0);
    endtask

    initial begin
        vecs[0] = '{"addi", 32'h0010_0093, 1'b1, 3'd0, 1'b0, 1'b0, 5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"sd",   32'h0011_3023, 1'b1, 3'd0, 1'b0, 1'b1, 7, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{"ld",   32'h0001_3083, 1'b1, 3'd0, 1'b1, 1'b0, 7, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{"jal",  32'h0080_00ef, 1'b1, 3'd1, 1'b0, 1'b0, 5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"jalr", 32'h0000_80e7, 1'b1, 3'd2, 1'b0, 1'b0, 5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"br5",  32'h0000_00b7, 1'b1, 3'd5, 1'b0, 1'b0, 5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        set_dec(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset("reset");

        // Fetch backpressure with a stale response pulse while still in FETCH_REQ.
        irdy_cfg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(i == 1);
            chk($sformatf("backpressure/valid_%0d", i), 64'(imem_req_valid), 64'd1);
            chk($sformatf("backpressure/ir_%0d", i), 64'(ir), 64'(NOP));
        end
        irdy_cfg = 1'b1;

        for (int i = 0; i < 6; i++) run_insn(vecs[i]);

        run_halt("ebreak", 1'b0, 1'b1, 2'd0);
        run_halt("illegal", 1'b1, 1'b1, 2'd1);

        reset_mid("rst_mem_wait", 1'b1);
        reset_mid("rst_fetch_wait", 1'b0);

        run_insn(vecs[0]);

        // Data memory never accepts.
        begin
            int cyc = 0, memreq = 0, halts = 0;
            cur_insn = 32'h0001_3083;
            set_dec(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            drdy_cfg = 1'b0;
`ifdef SEQ_TIMEOUT_EN
            while (!halt && cyc < 80) begin
                tick(1'b0);
                cyc++;
                if (dmem_req_valid) memreq++;
            end
            chk("timeout/halt", 64'(halt), 64'd1);
            chk("timeout/cause", 64'(halt_cause), 64'd2);
            chk("timeout/mem_req_cycles", 64'(memreq), 64'd16);
`else
            for (int i = 0; i < 1000; i++) begin
                tick(1'b0);
                if (halt) halts++;
                if (dmem_req_valid) memreq++;
            end
            chk("no_timeout/halt_cycles", 64'(halts), 64'd0);
            chk("no_timeout/mem_req_held", 64'(memreq), 64'd996);
            chk("no_timeout/last_valid", 64'(dmem_req_valid), 64'd1);
`endif
            drdy_cfg = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
